// File: rtl/audio_rec_seq_pkg.sv
// Shared definitions for the record/playback sequencer.
// Holds the FSM state encoding and the default bus widths.
// Also holds the access-length limit that sizes the strobe counter.
package audio_rec_seq_pkg;

  localparam int ADDR_W_DEF     = 18;
  localparam int DATA_W_DEF     = 16;
  localparam int ACC_CYCLES_MAX = 15;
  localparam int ACC_CNT_W      = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REC_WAIT  = 3'd1,
    REC_ACC   = 3'd2,
    PLAY_WAIT = 3'd3,
    PLAY_ACC  = 3'd4,
    PAUSED    = 3'd5
  } state_t;

endpackage

// File: rtl/audio_rec_seq.sv
// Record/playback sequencer: writes codec samples to consecutive SRAM words and reads them back in order.
// Latency: each strobe opens a read/write of ACC_CYCLES clocks; a played sample appears one clock after its read ends.
// Backpressure: none; a sample strobe that arrives while an access is in flight is dropped.
module audio_rec_seq
  import audio_rec_seq_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ACC_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_rec,
  input  logic              start_play,
  input  logic              stop,
  input  logic              pause,
  input  logic              smp_stb,
  input  logic [DATA_W-1:0] smp_in,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] addr,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] wr_data,
  output logic              record,
  output logic              play,
  output logic [DATA_W-1:0] smp_out,
  output logic              smp_out_vld,
  // One bit wider than addr so that a completely filled memory (2^ADDR_W samples)
  // is distinguishable from "nothing recorded".
  output logic [ADDR_W:0]   rec_len,
  output logic              full,
  output logic              done,
  output logic              busy
);

  state_t                 state, state_nxt;
  logic [ACC_CNT_W-1:0]   acc_cnt;
  logic                   paused_play;  // PAUSED was entered from playback
  logic                   stop_pend;    // stop seen during an access, honoured when it ends
  logic                   in_acc;
  logic                   acc_last;
  logic                   addr_last;
  logic                   play_end;
  logic [ADDR_W:0]        addr_inc;

  assign in_acc    = (state == REC_ACC) || (state == PLAY_ACC);
  assign acc_last  = (acc_cnt == ACC_CNT_W'(ACC_CYCLES - 1));
  assign addr_inc  = {1'b0, addr} + 1'b1;
  assign addr_last = &addr;
  assign play_end  = (addr_inc == rec_len);

  assign write  = (state == REC_ACC);
  assign read   = (state == PLAY_ACC);
  assign record = (state == REC_WAIT) || (state == REC_ACC);
  assign play   = (state == PLAY_WAIT) || (state == PLAY_ACC) || ((state == PAUSED) && paused_play);
  assign busy   = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: stop beats pause beats sample strobe; accesses always run to completion
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_rec)                         state_nxt = REC_WAIT;
        else if (start_play && rec_len != '0)  state_nxt = PLAY_WAIT;
      end
      REC_WAIT: begin
        if (stop)         state_nxt = IDLE;
        else if (pause)   state_nxt = PAUSED;
        else if (smp_stb) state_nxt = REC_ACC;
      end
      PLAY_WAIT: begin
        if (stop)         state_nxt = IDLE;
        else if (pause)   state_nxt = PAUSED;
        else if (smp_stb) state_nxt = PLAY_ACC;
      end
      PAUSED: begin
        if (stop)       state_nxt = IDLE;
        else if (pause) state_nxt = paused_play ? PLAY_WAIT : REC_WAIT;
      end
      REC_ACC: begin
        if (acc_last) state_nxt = (stop_pend || stop || addr_last) ? IDLE : REC_WAIT;
      end
      PLAY_ACC: begin
        if (acc_last) state_nxt = (stop_pend || stop || play_end) ? IDLE : PLAY_WAIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address, length, sample and flag registers updated alongside the state transitions
  always_ff @(posedge clk) begin
    if (reset) begin
      addr        <= '0;
      wr_data     <= '0;
      smp_out     <= '0;
      smp_out_vld <= 1'b0;
      rec_len     <= '0;
      full        <= 1'b0;
      done        <= 1'b0;
      acc_cnt     <= '0;
      paused_play <= 1'b0;
      stop_pend   <= 1'b0;
    end else begin
      smp_out_vld <= 1'b0;
      done        <= 1'b0;
      acc_cnt     <= (in_acc && !acc_last) ? acc_cnt + 1'b1 : '0;
      case (state)
        IDLE: begin
          if (start_rec) begin
            addr    <= '0;
            rec_len <= '0;
            full    <= 1'b0;
          end else if (start_play && rec_len != '0) begin
            addr <= '0;
          end
        end
        REC_WAIT: begin
          if (!stop && pause)                   paused_play <= 1'b0;
          else if (!stop && !pause && smp_stb)  wr_data     <= smp_in;
        end
        PLAY_WAIT: begin
          if (!stop && pause) paused_play <= 1'b1;
        end
        REC_ACC: begin
          if (stop) stop_pend <= 1'b1;
          if (acc_last) begin
            stop_pend <= 1'b0;
            rec_len   <= addr_inc;
            if (addr_last) full <= 1'b1;
            else           addr <= addr_inc[ADDR_W-1:0];
          end
        end
        PLAY_ACC: begin
          if (stop) stop_pend <= 1'b1;
          if (acc_last) begin
            stop_pend   <= 1'b0;
            smp_out     <= rd_data;
            smp_out_vld <= 1'b1;
            addr        <= addr_inc[ADDR_W-1:0];
            done        <= play_end;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_rec_seq.sv
// Self-checking bench for audio_rec_seq with a small SRAM model and transaction monitors.
// Expected write/read/playback sequences come from a queue of recorded samples.
// Stimulus uses random sample values, random strobe spacing and random recording lengths.
module tb_audio_rec_seq;

  localparam int AW  = 3;
  localparam int DW  = 16;
  localparam int ACC = 2;

  localparam int P_START_REC  = 0;
  localparam int P_START_PLAY = 1;
  localparam int P_STOP       = 2;
  localparam int P_PAUSE      = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_rec, start_play, stop, pause, smp_stb;
  logic [DW-1:0] smp_in;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] addr;
  logic          read, write;
  logic [DW-1:0] wr_data;
  logic          record, play;
  logic [DW-1:0] smp_out;
  logic          smp_out_vld;
  logic [AW:0]   rec_len;
  logic          full, done, busy;

  always #5 clk = ~clk;

  audio_rec_seq #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYCLES(ACC)) dut (
    .clk(clk), .reset(reset),
    .start_rec(start_rec), .start_play(start_play), .stop(stop), .pause(pause),
    .smp_stb(smp_stb), .smp_in(smp_in), .rd_data(rd_data),
    .addr(addr), .read(read), .write(write), .wr_data(wr_data),
    .record(record), .play(play), .smp_out(smp_out), .smp_out_vld(smp_out_vld),
    .rec_len(rec_len), .full(full), .done(done), .busy(busy)
  );

  // SRAM model: combinational read, written when a write pulse completes
  logic [DW-1:0] mem [1<<AW];
  assign rd_data = mem[addr];

  typedef struct { int a; int d; int len; } acc_t;
  acc_t wq[$];
  acc_t rq[$];
  int   vq[$];
  int   model_q[$];
  int   done_cnt;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: collapses strobe pulses into transactions and checks invariants
  int   wr_run = 0, rd_run = 0;
  acc_t wcur, rcur;
  always @(negedge clk) begin
    chk("rw_excl", int'(read && write), 0);
    if (write) begin
      if (wr_run == 0) begin
        wcur.a = int'(addr); wcur.d = int'(wr_data);
      end else begin
        chk("wr_stable", int'({addr, wr_data}), int'({wcur.a[AW-1:0], wcur.d[DW-1:0]}));
      end
      wr_run++;
    end else if (wr_run > 0) begin
      wcur.len = wr_run;
      wq.push_back(wcur);
      mem[wcur.a] = wcur.d[DW-1:0];
      wr_run = 0;
    end
    if (read) begin
      if (rd_run == 0) rcur.a = int'(addr);
      else chk("rd_stable", int'(addr), rcur.a);
      rd_run++;
    end else if (rd_run > 0) begin
      rcur.len = rd_run; rcur.d = 0;
      rq.push_back(rcur);
      rd_run = 0;
    end
    if (smp_out_vld) vq.push_back(int'(smp_out));
    if (done) begin
      done_cnt++;
      chk("done_with_vld", int'(smp_out_vld), 1);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input int which);
    case (which)
      P_START_REC:  start_rec  = 1'b1;
      P_START_PLAY: start_play = 1'b1;
      P_STOP:       stop       = 1'b1;
      default:      pause      = 1'b1;
    endcase
    tick(1);
    start_rec = 1'b0; start_play = 1'b0; stop = 1'b0; pause = 1'b0;
  endtask

  task automatic strobe(input int v, input int gap);
    smp_in  = DW'(v);
    smp_stb = 1'b1;
    tick(1);
    smp_stb = 1'b0;
    smp_in  = DW'($urandom);
    tick(gap);
  endtask

  task automatic do_record(input int n, input bit fixed);
    int v;
    model_q.delete(); wq.delete();
    pulse(P_START_REC);
    for (int i = 0; i < n; i++) begin
      v = fixed ? (i + 1) * 'h11 : int'($urandom_range(0, 65535));
      model_q.push_back(v);
      strobe(v, int'($urandom_range(3, 6)));
    end
    pulse(P_STOP);
    tick(2);
    chk("wr_count", wq.size(), n);
    for (int i = 0; i < wq.size() && i < n; i++) begin
      chk("wr_addr", wq[i].a, i);
      chk("wr_data", wq[i].d, model_q[i]);
      chk("wr_len", wq[i].len, ACC);
    end
    chk("rec_len", int'(rec_len), model_q.size());
    chk("full", int'(full), int'(n == (1 << AW)));
    chk("busy_after_rec", int'(busy), 0);
  endtask

  task automatic do_play(input int n);
    vq.delete(); rq.delete(); done_cnt = 0;
    pulse(P_START_PLAY);
    chk("play_flag", int'(play), 1);
    for (int i = 0; i < n; i++) strobe(int'($urandom), int'($urandom_range(3, 6)));
    tick(2);
    chk("vld_count", vq.size(), n);
    for (int i = 0; i < vq.size() && i < n; i++) chk("smp_out", vq[i], model_q[i]);
    chk("rd_count", rq.size(), n);
    for (int i = 0; i < rq.size() && i < n; i++) begin
      chk("rd_addr", rq[i].a, i);
      chk("rd_len", rq[i].len, ACC);
    end
    chk("done_count", done_cnt, 1);
    chk("busy_after_play", int'(busy), 0);
    chk("play_after_done", int'(play), 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    reset = 1'b1; start_rec = 1'b0; start_play = 1'b0; stop = 1'b0; pause = 1'b0;
    smp_stb = 1'b0; smp_in = '0; done_cnt = 0;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("reset_state", int'({addr, read, write, record, play, busy, full, rec_len}), 0);

    // Reset held three cycles in the middle of a write access
    pulse(P_START_REC);
    smp_in = 16'hBEEF; smp_stb = 1'b1;
    tick(1);
    smp_stb = 1'b0;
    chk("in_rec_acc", int'(write), 1);
    reset = 1'b1;
    tick(1);
    chk("rst_ctl", int'({addr, read, write, record, play, smp_out_vld, rec_len, full, done, busy}), 0);
    chk("rst_dat", int'({wr_data, smp_out}), 0);
    tick(2);
    reset = 1'b0;
    tick(2);

    // Four fixed samples recorded and played back
    do_record(4, 1'b1);
    do_play(4);

    // Empty recording: start_play ignored; simultaneous starts favour record
    do_record(0, 1'b0);
    rq.delete();
    pulse(P_START_PLAY);
    tick(3);
    chk("empty_play_busy", int'(busy), 0);
    chk("empty_play_reads", rq.size(), 0);
    start_rec = 1'b1; start_play = 1'b1;
    tick(1);
    start_rec = 1'b0; start_play = 1'b0;
    chk("both_record", int'(record), 1);
    chk("both_play", int'(play), 0);
    pulse(P_STOP);
    tick(1);

    // Pause during playback, then stop in the middle of a read
    do_record(4, 1'b0);
    vq.delete(); rq.delete(); done_cnt = 0;
    pulse(P_START_PLAY);
    pulse(P_PAUSE);
    chk("paused_play", int'(play), 1);
    chk("paused_busy", int'(busy), 1);
    for (int i = 0; i < 3; i++) strobe(int'($urandom), 3);
    chk("paused_reads", rq.size(), 0);
    pulse(P_PAUSE);
    chk("resume_addr", int'(addr), 0);
    strobe(int'($urandom), 3);
    strobe(int'($urandom), 3);
    strobe(int'($urandom), 0);
    pulse(P_STOP);
    tick(4);
    chk("stop_vld_count", vq.size(), 3);
    for (int i = 0; i < vq.size() && i < 3; i++) chk("stop_smp_out", vq[i], model_q[i]);
    chk("stop_rd_count", rq.size(), 3);
    chk("stop_no_done", done_cnt, 0);
    chk("stop_idle", int'(busy), 0);

    // Fill the whole memory, then confirm an extra strobe writes nothing
    do_record(1 << AW, 1'b0);
    wq.delete();
    strobe(16'h5A5A, 3);
    chk("after_full_writes", wq.size(), 0);
    chk("after_full_len", int'(rec_len), 1 << AW);
    chk("after_full_flag", int'(full), 1);
    do_play(1 << AW);

    // Random-length record/playback rounds
    repeat (4) begin
      int n;
      n = int'($urandom_range(1, 1 << AW));
      do_record(n, 1'b0);
      do_play(n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
